// File: rtl/packet_rx_pkg.sv
// Shared types and helpers for the packet receive router: FSM encoding, overflow modes,
// and buffer entry / flattened-bus index helpers.
package packet_rx_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARM     = 2'd1,
    COLLECT = 2'd2,
    COMMIT  = 2'd3
  } rx_state_e;

  localparam int unsigned OVF_DROP_OLDEST = 0;
  localparam int unsigned OVF_DROP_NEWEST = 1;

  // Entry is {payload, valid}; the valid bit lets empty slots read all-zero.
  function automatic int unsigned entry_w(input int unsigned payload_w);
    return payload_w + 1;
  endfunction

  function automatic int unsigned flat_lsb(input int unsigned ch, input int unsigned slot,
                                           input int unsigned depth, input int unsigned e_w);
    return (ch * depth + slot) * e_w;
  endfunction

endpackage

// File: rtl/rx_shift_buf.sv
// Per-channel shift buffer: slot 0 is the oldest entry, pops shift down, overflow
// either evicts the oldest entry or discards the incoming one.
module rx_shift_buf
  import packet_rx_pkg::*;
#(
  parameter int unsigned DEPTH     = 6,
  parameter int unsigned PAYLOAD_W = 2,
  parameter int unsigned OVF_MODE  = OVF_DROP_OLDEST,
  localparam int unsigned E_W      = entry_w(PAYLOAD_W),
  localparam int unsigned OCC_W    = $clog2(DEPTH + 1)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic                   pop,
  input  logic [PAYLOAD_W-1:0]   data,
  output logic [DEPTH*E_W-1:0]   slots,
  output logic [OCC_W-1:0]       occ,
  output logic                   drop,
  output logic [PAYLOAD_W-1:0]   pop_data
);

  logic [E_W-1:0]   slot_q [DEPTH];
  logic [E_W-1:0]   slot_d [DEPTH];
  logic [OCC_W-1:0] occ_d;
  logic [OCC_W-1:0] wr_idx;
  logic             drop_d;
  logic             full;
  logic             do_pop;
  logic             shift;
  logic             wr_en;

  assign full   = (occ == OCC_W'(DEPTH));
  assign do_pop = pop && (occ != '0);

  // Pop shifts first; a same-cycle push then lands in the slot the pop freed.
  always_comb begin
    slot_d = slot_q;
    occ_d  = occ;
    drop_d = 1'b0;
    shift  = do_pop;
    wr_en  = push;
    wr_idx = occ;
    if (push) begin
      if (do_pop) begin
        wr_idx = occ - OCC_W'(1);
      end else if (full) begin
        drop_d = 1'b1;
        if (OVF_MODE == OVF_DROP_OLDEST) begin
          shift  = 1'b1;
          wr_idx = OCC_W'(DEPTH - 1);
        end else begin
          wr_en = 1'b0;
        end
      end else begin
        occ_d = occ + OCC_W'(1);
      end
    end else if (do_pop) begin
      occ_d = occ - OCC_W'(1);
    end
    if (shift) begin
      for (int s = 0; s < DEPTH - 1; s++) slot_d[s] = slot_q[s+1];
      slot_d[DEPTH-1] = '0;
    end
    for (int s = 0; s < DEPTH; s++) begin
      if (wr_en && (wr_idx == OCC_W'(s))) slot_d[s] = {data, 1'b1};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < DEPTH; s++) slot_q[s] <= '0;
      occ  <= '0;
      drop <= 1'b0;
    end else begin
      slot_q <= slot_d;
      occ    <= occ_d;
      drop   <= drop_d;
    end
  end

  for (genvar s = 0; s < DEPTH; s++) begin : g_flat
    assign slots[s*E_W +: E_W] = slot_q[s];
  end

  assign pop_data = slot_q[0][E_W-1:1];

endmodule

// File: rtl/packet_rx_router.sv
// Key-driven packet entry: assembles packets bit-by-bit from two active-low keys and routes
// each to a per-channel shift buffer by its ID, with a pop port and saturating statistics.
module packet_rx_router
  import packet_rx_pkg::*;
#(
  parameter int unsigned NUM_CH    = 4,
  parameter int unsigned PAYLOAD_W = 2,
  parameter int unsigned DEPTH     = 6,
  parameter int unsigned ARM_CYC   = 3,
  parameter int unsigned OVF_MODE  = OVF_DROP_OLDEST,
  parameter int unsigned CNT_W     = 8,
  localparam int unsigned ID_W     = $clog2(NUM_CH),
  localparam int unsigned PKT_W    = ID_W + PAYLOAD_W,
  localparam int unsigned E_W      = entry_w(PAYLOAD_W),
  localparam int unsigned OCC_W    = $clog2(DEPTH + 1)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic                        key0,
  input  logic                        key1,
  input  logic                        rd_en,
  input  logic [ID_W-1:0]             rd_ch,
  output logic [PAYLOAD_W-1:0]        rd_data,
  output logic                        rd_valid,
  output logic [NUM_CH*DEPTH*E_W-1:0] buf_o,
  output logic [NUM_CH*OCC_W-1:0]     occ_o,
  output logic [PKT_W-1:0]            last_pkt,
  output logic [CNT_W-1:0]            pkt_cnt,
  output logic [CNT_W-1:0]            drop_cnt,
  output logic                        busy
);

  localparam int unsigned BIT_W = $clog2(PKT_W + 1);
  localparam int unsigned ARM_W = $clog2(ARM_CYC + 1);

  rx_state_e            state, state_nxt;
  logic [ARM_W-1:0]     arm_cnt;
  logic [BIT_W-1:0]     bit_cnt;
  logic [PKT_W-1:0]     shreg;
  logic                 wait_rel;
  logic                 accept;
  logic                 bit_val;
  logic [ID_W-1:0]      commit_id;
  logic [NUM_CH-1:0]    push_v;
  logic [NUM_CH-1:0]    pop_v;
  logic [NUM_CH-1:0]    drop_v;
  logic [OCC_W-1:0]     occ_a      [NUM_CH];
  logic [PAYLOAD_W-1:0] pop_data_a [NUM_CH];
  logic                 rd_hit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // {key0,key1}: 01 -> bit 0, 10 -> bit 1; a new bit needs a full release first.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    bit_val   = 1'b0;
    case (state)
      IDLE:    if (start) state_nxt = ARM;
      ARM: begin
        if (!start)                                state_nxt = IDLE;
        else if (arm_cnt == ARM_W'(ARM_CYC - 1))   state_nxt = COLLECT;
      end
      COLLECT: begin
        if (!start) begin
          state_nxt = IDLE;
        end else if (!wait_rel && (key0 ^ key1)) begin
          accept  = 1'b1;
          bit_val = ~key1;
          if (bit_cnt == BIT_W'(PKT_W - 1)) state_nxt = COMMIT;
        end
      end
      COMMIT:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign commit_id = shreg[PKT_W-1 -: ID_W];
  assign rd_hit    = rd_en && (occ_a[rd_ch] != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      arm_cnt  <= '0;
      bit_cnt  <= '0;
      wait_rel <= 1'b0;
      shreg    <= '0;
      busy     <= 1'b0;
      last_pkt <= '0;
      pkt_cnt  <= '0;
      drop_cnt <= '0;
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      busy    <= (state_nxt != IDLE);
      arm_cnt <= (state == ARM) ? arm_cnt + ARM_W'(1) : '0;
      if (state == ARM) begin
        bit_cnt  <= '0;
        wait_rel <= 1'b0;
        shreg    <= '0;
      end else if (accept) begin
        bit_cnt  <= bit_cnt + BIT_W'(1);
        wait_rel <= 1'b1;
        shreg    <= {shreg[PKT_W-2:0], bit_val};
      end else if ((state == COLLECT) && key0 && key1) begin
        wait_rel <= 1'b0;
      end
      if (state == COMMIT) begin
        last_pkt <= shreg;
        if (pkt_cnt != '1) pkt_cnt <= pkt_cnt + CNT_W'(1);
      end
      if ((|drop_v) && (drop_cnt != '1)) drop_cnt <= drop_cnt + CNT_W'(1);
      rd_valid <= rd_hit;
      if (rd_hit) rd_data <= pop_data_a[rd_ch];
    end
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    assign push_v[c] = (state == COMMIT) && (commit_id == ID_W'(c));
    assign pop_v[c]  = rd_en && (rd_ch == ID_W'(c));
    assign occ_a[c]  = occ_o[c*OCC_W +: OCC_W];

    rx_shift_buf #(
      .DEPTH     (DEPTH),
      .PAYLOAD_W (PAYLOAD_W),
      .OVF_MODE  (OVF_MODE)
    ) u_buf (
      .clk      (clk),
      .rst_n    (rst_n),
      .push     (push_v[c]),
      .pop      (pop_v[c]),
      .data     (shreg[PAYLOAD_W-1:0]),
      .slots    (buf_o[flat_lsb(c, 0, DEPTH, E_W) +: DEPTH*E_W]),
      .occ      (occ_o[c*OCC_W +: OCC_W]),
      .drop     (drop_v[c]),
      .pop_data (pop_data_a[c])
    );
  end

endmodule

// File: tb/tb_packet_rx_router.sv
// Directed bench: default, drop-newest and 8-channel instances share one key stream.
module tb_packet_rx_router;

  logic clk, rst_n, start, key0, key1, rd_en;
  logic [1:0] rd_ch;
  logic [2:0] rd_ch_c;

  logic [1:0]   rd_data_a, rd_data_b;
  logic         rd_valid_a, rd_valid_b, busy_a, busy_b;
  logic [71:0]  buf_a, buf_b;
  logic [11:0]  occ_a, occ_b;
  logic [3:0]   last_a, last_b;
  logic [7:0]   pkt_a, pkt_b, drop_a, drop_b;

  logic [2:0]   rd_data_c;
  logic         rd_valid_c, busy_c;
  logic [127:0] buf_c;
  logic [23:0]  occ_c;
  logic [5:0]   last_c;
  logic [7:0]   pkt_c, drop_c;

  int checks = 0;
  int failures = 0;
  logic [17:0] exp18;

  packet_rx_router u_a (
    .clk(clk), .rst_n(rst_n), .start(start), .key0(key0), .key1(key1),
    .rd_en(rd_en), .rd_ch(rd_ch), .rd_data(rd_data_a), .rd_valid(rd_valid_a),
    .buf_o(buf_a), .occ_o(occ_a), .last_pkt(last_a), .pkt_cnt(pkt_a),
    .drop_cnt(drop_a), .busy(busy_a)
  );

  packet_rx_router #(.OVF_MODE(1)) u_b (
    .clk(clk), .rst_n(rst_n), .start(start), .key0(key0), .key1(key1),
    .rd_en(rd_en), .rd_ch(rd_ch), .rd_data(rd_data_b), .rd_valid(rd_valid_b),
    .buf_o(buf_b), .occ_o(occ_b), .last_pkt(last_b), .pkt_cnt(pkt_b),
    .drop_cnt(drop_b), .busy(busy_b)
  );

  packet_rx_router #(.NUM_CH(8), .PAYLOAD_W(3), .DEPTH(4)) u_c (
    .clk(clk), .rst_n(rst_n), .start(start), .key0(key0), .key1(key1),
    .rd_en(rd_en), .rd_ch(rd_ch_c), .rd_data(rd_data_c), .rd_valid(rd_valid_c),
    .buf_o(buf_c), .occ_o(occ_c), .last_pkt(last_c), .pkt_cnt(pkt_c),
    .drop_cnt(drop_c), .busy(busy_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [143:0] obs, input logic [143:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic arm();
    start = 1'b1; key0 = 1'b1; key1 = 1'b1;
    tick(4);
  endtask

  task automatic press(input logic b);
    key0 = b; key1 = ~b;
    tick(1);
    key0 = 1'b1; key1 = 1'b1;
    tick(1);
  endtask

  task automatic send_pkt(input logic [5:0] bits, input int nbits);
    arm();
    for (int i = nbits - 1; i >= 0; i--) press(bits[i]);
    start = 1'b0;
    tick(1);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; key0 = 1'b1; key1 = 1'b1;
    rd_en = 1'b0; rd_ch = 2'd0; rd_ch_c = 3'd0;
    tick(2);
    rst_n = 1'b1;
    tick(1);
    chk("reset_a", {buf_a, occ_a, last_a, pkt_a, drop_a, rd_data_a, rd_valid_a, busy_a}, '0);
    chk("reset_c", {buf_c, pkt_c, busy_c}, '0);

    // 1: packet 1011 -> ch2 payload 11
    send_pkt(6'b001011, 4);
    chk("t1_ch2_slot0", buf_a[36 +: 3], 3'b111);
    chk("t1_occ_ch2", occ_a[8:6], 3'd1);
    chk("t1_last_pkt", last_a, 4'b1011);
    chk("t1_pkt_cnt", pkt_a, 8'd1);
    chk("t1_busy", busy_a, 1'b0);

    // 2: seven packets to ch0, payload i mod 4
    for (int i = 0; i < 7; i++) begin
      send_pkt(6'({2'b00, 2'(i)}), 4);
      if (i == 5) chk("t2_no_drop_yet", drop_a, 8'd0);
    end
    for (int s = 0; s < 6; s++) exp18[s*3 +: 3] = {2'(s + 1), 1'b1};
    chk("t2_ovf0_ch0", buf_a[17:0], exp18);
    for (int s = 0; s < 6; s++) exp18[s*3 +: 3] = {2'(s), 1'b1};
    chk("t2_ovf1_ch0", buf_b[17:0], exp18);
    chk("t2_occ_a", occ_a[2:0], 3'd6);
    chk("t2_occ_b", occ_b[2:0], 3'd6);
    chk("t2_drop_a", drop_a, 8'd1);
    chk("t2_drop_b", drop_b, 8'd1);
    chk("t2_pkt_cnt", pkt_a, 8'd8);

    // 3: held key, both-low ignored, then 1,1,1 -> packet 0111
    arm();
    key0 = 1'b0; key1 = 1'b1; tick(10);
    key0 = 1'b1; key1 = 1'b1; tick(1);
    key0 = 1'b0; key1 = 1'b0; tick(3);
    key0 = 1'b1; key1 = 1'b1; tick(1);
    press(1'b1); press(1'b1); press(1'b1);
    start = 1'b0; tick(1);
    chk("t3_held_last", last_a, 4'b0111);
    chk("t3_held_pkt_cnt", pkt_a, 8'd9);
    chk("t3_ch1_slot0", buf_a[18 +: 3], 3'b111);
    arm();
    press(1'b1); press(1'b0);
    start = 1'b0; tick(2);
    chk("t3_abort_busy", busy_a, 1'b0);
    chk("t3_abort_pkt_cnt", pkt_a, 8'd9);
    chk("t3_abort_last", last_a, 4'b0111);

    // 4: fill ch1, then pop ch1 in the commit cycle of packet 0110
    for (int i = 0; i < 5; i++) send_pkt(6'({2'b01, 2'(i)}), 4);
    chk("t4_occ_full", occ_a[5:3], 3'd6);
    arm();
    press(1'b0); press(1'b1); press(1'b1);
    key0 = 1'b0; key1 = 1'b1; tick(1);
    key0 = 1'b1; key1 = 1'b1; rd_en = 1'b1; rd_ch = 2'd1;
    tick(1);
    chk("t4_rd_valid", rd_valid_a, 1'b1);
    chk("t4_rd_data", rd_data_a, 2'd3);
    rd_en = 1'b0; start = 1'b0;
    tick(1);
    chk("t4_occ_kept", occ_a[5:3], 3'd6);
    chk("t4_drop_kept", drop_a, 8'd1);
    chk("t4_ch1_slots", buf_a[18 +: 18], 18'b101_001_111_101_011_001);
    chk("t4_pkt_cnt", pkt_a, 8'd15);
    rd_en = 1'b1; rd_ch = 2'd3;
    tick(1);
    chk("t4_empty_valid", rd_valid_a, 1'b0);
    chk("t4_empty_hold", rd_data_a, 2'd3);
    rd_ch = 2'd0;
    tick(1);
    rd_en = 1'b0;
    chk("t4_pop0_a", {rd_valid_a, rd_data_a}, 3'b101);
    chk("t4_pop0_b", {rd_valid_b, rd_data_b}, 3'b100);
    tick(1);
    chk("t4_pop0_occ", occ_a[2:0], 3'd5);

    // 5: asynchronous reset mid-collect, then a clean packet 1101
    arm();
    press(1'b1); press(1'b0);
    chk("t5_busy_mid", busy_a, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_async_zero", {buf_a, occ_a, last_a, pkt_a, drop_a, rd_data_a, rd_valid_a, busy_a}, '0);
    start = 1'b0;
    tick(1);
    rst_n = 1'b1;
    tick(1);
    send_pkt(6'b001101, 4);
    chk("t5_ch3_slot0", buf_a[54 +: 3], 3'b011);
    chk("t5_occ_ch3", occ_a[11:9], 3'd1);
    chk("t5_pkt_cnt", pkt_a, 8'd1);

    // 6: 8-channel instance, routing of ID 5 and counter saturation
    rst_n = 1'b0; tick(1); rst_n = 1'b1; tick(1);
    send_pkt({3'd5, 3'd6}, 6);
    chk("t6_ch5_slot0", buf_c[80 +: 4], 4'b1101);
    chk("t6_occ_ch5", occ_c[17:15], 3'd1);
    chk("t6_occ_ch0", occ_c[2:0], 3'd0);
    for (int i = 1; i < 260; i++) begin
      send_pkt({3'(i), 3'(i)}, 6);
      if (i == 254) chk("t6_cnt_255", pkt_c, 8'd255);
    end
    chk("t6_cnt_sat", pkt_c, 8'd255);
    chk("t6_drop_cnt", drop_c, 8'd228);
    chk("t6_last_pkt", last_c, 6'b011011);
    rd_en = 1'b1; rd_ch_c = 3'd5;
    tick(1);
    rd_en = 1'b0;
    chk("t6_pop_ch5", {rd_valid_c, rd_data_c}, 4'b1101);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
